alu_mdu: RTL and testbench

- Parametrised successor to the combinational execute-stage ALU.
- Keeps the ten base RV32I operations and adds the RV32M multiply/divide group.
- Output is registered with a valid/ready handshake, so the EX stage can stall on multi-cycle divides.
- Sits between the ID/EX pipeline register and EX/MEM; hazard unit uses in_ready to freeze upstream stages.

---
 rtl/alu_mdu_pkg.sv | 30 +++
 rtl/alu_mdu_div_iter.sv | 79 +++++++
 rtl/alu_mdu.sv | 165 ++++++++++++++++
 tb/tb_alu_mdu.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared opcode map and FSM encoding for the execute-stage ALU/MDU.
// Imported by the RTL and by the bench so both decode the same values.
package alu_mdu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_XOR    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_AND    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_SLT    = 5'b01000;
    localparam logic [4:0] ALU_SLTU   = 5'b01001;

    localparam logic [4:0] MDU_MUL    = 5'b10000;
    localparam logic [4:0] MDU_MULH   = 5'b10001;
    localparam logic [4:0] MDU_MULHSU = 5'b10010;
    localparam logic [4:0] MDU_MULHU  = 5'b10011;
    localparam logic [4:0] MDU_DIV    = 5'b10100;
    localparam logic [4:0] MDU_DIVU   = 5'b10101;
    localparam logic [4:0] MDU_REM    = 5'b10110;
    localparam logic [4:0] MDU_REMU   = 5'b10111;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mdu_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done pulses for one cycle after the last of XLEN iterations.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    always_comb begin
        trial  = {rem_q, quo_q[XLEN-1]};
        diff   = trial - {1'b0, dsr_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (kill) begin
            run_d = 1'b0;
        end else if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = CW'(XLEN);
            run_d = 1'b1;
        end else if (run_q) begin
            // borrow out of the trial subtraction means "restore"
            rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage RV32I ALU plus RV32M multiply/divide.
// Registered result with valid/ready; divides stall via in_ready.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DIV_EARLY_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            rem_op_q, rem_op_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;

    logic            accept, is_div, b_zero, early, div_start, div_done;
    logic            sgn, a_neg, b_neg, sa, sb;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] mag_a, mag_b, quo, rem, div_res, alu_res;
    logic [2*XLEN-1:0] ma, mb, prod;

    assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign is_div    = op[4] & ~op[3] & op[2];
    assign b_zero    = (b == '0);
    assign early     = (DIV_EARLY_ZERO != 0) & b_zero;
    assign div_start = accept & is_div & ~early;

    assign sgn   = ~op[0];
    assign a_neg = sgn & a[XLEN-1];
    assign b_neg = sgn & b[XLEN-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
    assign shamt = b[SHW-1:0];

    // low 2*XLEN bits of the product are exact for any extension mix
    assign sa   = (op == MDU_MULH) | (op == MDU_MULHSU);
    assign sb   = (op == MDU_MULH);
    assign ma   = {{XLEN{sa & a[XLEN-1]}}, a};
    assign mb   = {{XLEN{sb & b[XLEN-1]}}, b};
    assign prod = ma * mb;

    always_comb begin
        alu_res = a + b;
        case (op)
            ALU_SUB:    alu_res = a - b;
            ALU_XOR:    alu_res = a ^ b;
            ALU_OR:     alu_res = a | b;
            ALU_AND:    alu_res = a & b;
            ALU_SLL:    alu_res = a << shamt;
            ALU_SRL:    alu_res = a >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a < b};
            MDU_MUL:    alu_res = prod[XLEN-1:0];
            MDU_MULH,
            MDU_MULHSU,
            MDU_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
            MDU_DIV,
            MDU_DIVU:   alu_res = '1;
            MDU_REM,
            MDU_REMU:   alu_res = a;
            default:    alu_res = a + b;
        endcase
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (flush),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    assign div_res = rem_op_q ? (neg_r_q ? -rem : rem)
                              : (neg_q_q ? -quo : quo);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        rem_op_d    = rem_op_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (out_valid_q & out_ready) out_valid_d = 1'b0;
                    if (div_start) begin
                        state_d  = DIV;
                        rem_op_d = op[1];
                        // x/0 keeps an all-ones quotient regardless of sign
                        neg_q_d  = (a_neg ^ b_neg) & ~b_zero;
                        neg_r_d  = a_neg;
                    end else if (accept) begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        result_d    = div_res;
                        zero_d      = (div_res == '0);
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            rem_op_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rem_op_q    <= rem_op_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q == DIV);

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: random ops vs a longint reference model.
// Also covers backpressure, flush, reset mid-divide and an XLEN=16 instance.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    logic        zero, busy;

    logic        in_valid16, in_ready16, out_valid16, zero16, busy16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, result16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rnd_bp = 1'b0;
    bit man_ready = 1'b1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    alu_mdu #(.XLEN(32), .DIV_EARLY_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_mdu #(.XLEN(16), .DIV_EARLY_ZERO(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(1'b1),
        .result(result16), .zero(zero16), .busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : man_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        int unsigned     sh = y % 32;
        case (o)
            ALU_SUB:    return x - y;
            ALU_XOR:    return x ^ y;
            ALU_OR:     return x | y;
            ALU_AND:    return x & y;
            ALU_SLL:    return x << sh;
            ALU_SRL:    return x >> sh;
            ALU_SRA:    return 32'(sx >>> sh);
            ALU_SLT:    return (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (ux < uy) ? 32'd1 : 32'd0;
            MDU_MUL:    return 32'(sx * sy);
            MDU_MULH:   return 32'((sx * sy) >>> 32);
            MDU_MULHSU: return 32'((sx * longint'(uy)) >>> 32);
            MDU_MULHU:  return 32'((ux * uy) >> 32);
            MDU_DIV:    return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            MDU_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            MDU_REM:    return (y == 0) ? x : 32'(sx % sy);
            MDU_REMU:   return (y == 0) ? x : 32'(ux % uy);
            default:    return x + y;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] o, input logic [31:0] y);
        return (o[4:2] == 3'b101 && y != 0) ? 33 : 0;
    endfunction

    bit          fresh = 1'b1;
    logic [31:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (fresh) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%h want=none", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("zero", zero, e.res == 0);
                    chk("latency", cyc - e.acc, e.lat);
                end
                held  = result;
                fresh = 1'b0;
            end else begin
                chk("hold", result, held);
            end
            if (out_ready) fresh = 1'b1;
        end else begin
            fresh = 1'b1;
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit expct, output int w);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        if (expct) sb.push_back('{model(o, x, y), cyc + 1, lat_of(o, y)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic busy_window(input string n);
        int nb = 0;
        repeat (33) begin
            @(negedge clk);
            if (!busy || out_valid || in_ready) nb++;
        end
        chk(n, nb, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic div16(input logic [4:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] want);
        int acc;
        int w = 0;
        op16 = o;
        a16 = x;
        b16 = y;
        in_valid16 = 1'b1;
        @(negedge clk);
        chk("x16_ready", in_ready16, 1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        while (!out_valid16 && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk("x16_result", result16, want);
        chk("x16_latency", cyc - acc, 17);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, nb;
        logic [4:0]  ro;
        logic [31:0] rx, ry;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        in_valid16 = 1'b0;
        op16 = '0;
        a16 = '0;
        b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 1, w);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, w);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1, w);
        issue(ALU_SUB, 32'd5, 32'd5, 1, w);
        issue(MDU_MULH, 32'h8000_0000, 32'h8000_0000, 1, w);
        issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, w);
        issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, w);
        issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 1, w);
        drain();

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1, w);
        busy_window("div_busy");
        issue(MDU_REM, 32'hFFFF_FFF9, 32'd2, 1, w);
        busy_window("rem_busy");
        issue(MDU_DIVU, 32'd100, 32'd0, 1, w);
        issue(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, w);
        drain();
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, w);
        drain();

        man_ready = 1'b0;
        issue(ALU_ADD, 32'd3, 32'd4, 1, w);
        op = ALU_ADD;
        a = 32'd10;
        b = 32'd20;
        in_valid = 1'b1;
        nb = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready || !out_valid || result != 32'd7) nb++;
        end
        chk("bp_hold", nb, 0);
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        issue(ALU_ADD, 32'd10, 32'd20, 1, w);
        chk("bp_release_wait", w, 0);
        drain();

        issue(MDU_DIV, 32'd1000, 32'd7, 0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        op = ALU_ADD;
        a = 32'd5;
        b = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nb++;
        end
        chk("flush_no_out", nb, 0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_accept", out_valid, 0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd1, 32'd1, 1, w);
        drain();

        issue(MDU_DIV, 32'd12345, 32'd67, 0, w);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_result", result, 0);
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) nb++;
        end
        chk("mid_rst_quiet", nb, 0);
        @(posedge clk);
        #1;

        div16(MDU_DIVU, 16'hFFFF, 16'd3, 16'h5555);
        div16(MDU_DIV, 16'hFFF9, 16'd2, 16'hFFFD);

        rnd_bp = 1'b1;
        repeat (300) begin
            ro = 5'($urandom_range(0, 31));
            rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'h8000_0000;
                default: ry = $urandom;
            endcase
            issue(ro, rx, ry, 1, w);
        end
        rnd_bp = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
